// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment to BCD decoder.
package seg7_pkg;

    // Segment patterns, common cathode, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_LOCK  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] CODE_LOCK = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HELD  = 2'd2
    } seg7_state_e;

endpackage

// File: rtl/seg7_to_bcd_if.sv
// Pattern input / decoded output bundle of the seven-segment decoder.
interface seg7_to_bcd_if;
    logic       en;
    logic [6:0] s;
    logic [3:0] bcd_output;
    logic       valid;
    logic       err;
    logic [7:0] err_cnt;

    modport master (
        output en, s,
        input  bcd_output, valid, err, err_cnt
    );

    modport slave (
        input  en, s,
        output bcd_output, valid, err, err_cnt
    );
endinterface

// File: rtl/seg7_pattern_lookup.sv
// Pure table lookup from segment pattern to code; blank and unknown
// patterns are flagged rather than decoded.
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] s,
    output logic [3:0] code,
    output logic       is_valid,
    output logic       is_blank
);

    // Decode the segment pattern against the digit / lock table
    always_comb begin
        code     = 4'h0;
        is_valid = 1'b1;
        is_blank = 1'b0;
        case (s)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_LOCK:  code = CODE_LOCK;
            SEG_BLANK: begin
                is_valid = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_to_bcd.sv
// Debounced seven-segment to BCD decoder: a pattern must be sampled
// identically on STABLE_CYCLES consecutive enabled edges before it is
// accepted; acceptance emits a one-cycle valid or err pulse.
module seg7_to_bcd
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic          clk,
    input logic          rst,
    seg7_to_bcd_if.slave bus
);

    // The counter holds (matching samples - 1), so acceptance happens when
    // the incremented count reaches STABLE_CYCLES-1.
    localparam logic [3:0] ACCEPT_CNT = 4'(STABLE_CYCLES - 1);

    seg7_state_e state_r;
    logic [6:0]  sample_q_r;
    logic [3:0]  cnt_r;
    logic [3:0]  bcd_r;
    logic        valid_r;
    logic        err_r;
    logic [7:0]  err_cnt_r;

    logic [3:0]  code_s;
    logic        is_valid_s;
    logic        is_blank_s;
    logic        same_s;
    logic [3:0]  cnt_inc_s;
    logic        accept_s;

    seg7_pattern_lookup u_lookup (
        .s        (bus.s),
        .code     (code_s),
        .is_valid (is_valid_s),
        .is_blank (is_blank_s)
    );

    // Stability comparison and saturating counter increment
    always_comb begin
        same_s    = (bus.s == sample_q_r);
        cnt_inc_s = (cnt_r == 4'hF) ? cnt_r : (cnt_r + 4'd1);
        accept_s  = same_s && (cnt_inc_s >= ACCEPT_CNT);
    end

    // Acceptance FSM with sample register, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            sample_q_r <= 7'b0000000;
            cnt_r      <= 4'd0;
            bcd_r      <= 4'd0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            err_cnt_r  <= 8'd0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            if (bus.en) begin
                sample_q_r <= bus.s;
                cnt_r      <= same_s ? cnt_inc_s : 4'd0;
                case (state_r)
                    ST_IDLE: begin
                        // First enabled edge is the first sample of a fresh count
                        state_r <= ST_TRACK;
                        cnt_r   <= 4'd0;
                    end
                    ST_TRACK: begin
                        if (accept_s) begin
                            state_r <= ST_HELD;
                            if (is_valid_s) begin
                                bcd_r   <= code_s;
                                valid_r <= 1'b1;
                            end else if (!is_blank_s) begin
                                err_r <= 1'b1;
                                if (err_cnt_r != 8'hFF) begin
                                    err_cnt_r <= err_cnt_r + 8'd1;
                                end
                            end
                        end
                    end
                    ST_HELD: begin
                        if (!same_s) begin
                            state_r <= ST_TRACK;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.bcd_output = bcd_r;
    assign bus.valid      = valid_r;
    assign bus.err        = err_r;
    assign bus.err_cnt    = err_cnt_r;

endmodule

// File: doc/seg7_to_bcd.md
SEG7_TO_BCD -- requirements
Module: seg7_to_bcd

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..15: consecutive identical samples required before a pattern is accepted.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  sample enable; when 0, all internal state holds and no pulses issue.
REQ-005 s  input  7  segment pattern, common cathode, active-high; s[6]=a, s[5]=b, s[4]=c, s[3]=d, s[2]=e, s[1]=f, s[0]=g.
REQ-006 bcd_output  output  4  last accepted code: 0-9 for digits, 4'hA for the lock symbol.
REQ-007 valid  output  1  one-cycle pulse marking a newly accepted code on bcd_output.
REQ-008 err  output  1  one-cycle pulse marking a stable but unrecognised pattern.
REQ-009 err_cnt  output  8  saturating count of err pulses.

Function
REQ-010 Code table (s[6:0] to code): 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9, 0000001=A (lock).
REQ-011 7'b0000000 is blank: it is accepted like any other pattern but produces neither valid nor err, and it leaves bcd_output unchanged.
REQ-012 Any other pattern is invalid.
REQ-013 s is registered into sample_q on every edge with en=1.
REQ-014 The stability counter clears when s differs from sample_q, and increments (saturating) when s equals sample_q.
REQ-015 FSM states:
- IDLE: after reset.
- TRACK: counting stability.
- HELD: pattern accepted; wait for a change.
REQ-016 IDLE goes to TRACK on the first edge with en=1.
REQ-017 TRACK goes to HELD on the edge at which the pattern has been sampled equal on STABLE_CYCLES consecutive enabled edges.
REQ-018 HELD goes to TRACK on the first enabled edge where s differs from sample_q.
REQ-019 On the TRACK-to-HELD edge:
- valid pattern: bcd_output updates and valid=1 for exactly the following cycle.
- invalid pattern: err=1 for exactly that cycle, and err_cnt increments.
- blank pattern: no pulse.
REQ-020 Latency: a pattern applied before enabled edge E1 and held produces valid/err in the cycle after edge E(STABLE_CYCLES).
REQ-021 A pattern held indefinitely in HELD produces no further pulses.
REQ-022 Re-presenting the same digit after any different intervening pattern (including blank) produces a new valid pulse.
REQ-023 A glitch shorter than STABLE_CYCLES samples produces no pulse.
- If the glitch returns to the held pattern, the FSM goes TRACK and re-accepts that pattern, issuing a fresh pulse.
REQ-024 en=0 mid-TRACK freezes the counter, sample_q and state; counting resumes when en returns to 1.
REQ-025 valid and err are never high in the same cycle.
REQ-026 err_cnt saturates at 255.
REQ-027 All outputs are registered.

Reset
REQ-028 rst=1 at a rising edge sets state=IDLE, sample_q=0, counter=0, bcd_output=0, valid=0, err=0, err_cnt=0, overriding en and any operation in progress.
REQ-029 The first enabled edge after rst deasserts starts counting from zero; no pulse issues from a pattern seen before or during reset.

Structure
REQ-030 Shared package seg7_pkg holds:
- the eleven segment constants of REQ-010 and SEG_BLANK;
- CODE_LOCK=4'hA;
- the FSM state typedef.
REQ-031 Sub-module seg7_pattern_lookup (combinational, s to {code, is_valid, is_blank}) holds the REQ-010 table; it has no other function.

Verification
REQ-032 Reset, then s=1101101 held 6 cycles with en=1 -> single valid pulse in the cycle after the 4th edge, bcd_output=2, err=0.
REQ-033 s=0110000 held 4 edges, then blank for 4 edges, then 0110000 again -> two valid pulses, bcd_output=1 both times, no pulse for blank.
REQ-034 s=1011111 held, 2-cycle glitch to 1111111, back to 1011111 -> no pulse for 8; a second valid pulse with bcd_output=6.
REQ-035 s=1010101 held 5 cycles, repeated 260 times with blank between -> err pulses, valid=0 throughout, err_cnt=255 at the end.
REQ-036 s=0000001 with en toggled 1,0,0,1,1,1 -> valid with bcd_output=A only after the 4th enabled edge.
REQ-037 rst asserted after 3 of 4 stable samples of 1111011 -> all outputs zero; pattern held -> valid with bcd_output=9 4 edges after rst release.
